sram_ctrl: RTL and testbench
============================

# sram_ctrl

Sequential controller between the PC/fetch stage and the off-chip base SRAM. Each cycle it samples the PC stage's `addr`/`ce`/`rom_op_o`/`wr_data_o` request and runs a multi-cycle SRAM read or write through a small FSM. While the access is in flight it holds a stall request to CTRL. It returns the read word (instruction or data) to the IF/ID path.

## Interface
Parameters:
- `SRAM_ADDR_W`, 20: SRAM word-address width.
- `WAIT_CYCLES`, 1: extra wait states per access. Range 1–7. Only used when `SRAM_WAIT_EN` is defined.

Ports:
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `addr_i` input 32: byte address from PC stage.
- `ce_i` input 1: request valid (`ChipEnable`).
- `rom_op_i` input 1: `ROM_OP_READ`/`ROM_OP_WRITE`.
- `wr_data_i` input 32: write data.
- `rdata_o` output 32: last read word (registered).
- `rdata_valid_o` output 1: one-cycle pulse, `rdata_o` updated.
- `stall_req_o` output 1: to CTRL. Freezes PC (`stall[0]`) while high.
- `sram_addr_o` output SRAM_ADDR_W: word address, `addr_i[SRAM_ADDR_W+1:2]`.
- `sram_wdata_o` output 32: write data. The top-level tri-state uses it.
- `sram_rdata_i` input 32: SRAM data-bus input.
- `sram_data_oe_o` output 1: top level drives the data bus when high.
- `sram_ce_n_o`, `sram_oe_n_o`, `sram_we_n_o` outputs 1 each: active-low SRAM strobes.
- `sram_be_n_o` output 4: byte enables. Always 4'b0000 (full word) while `sram_ce_n_o` is low, otherwise 4'b1111.

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - With `ce_i`=1, latch `addr_i`, `rom_op_i` and `wr_data_i`, then go to ACCESS.
  - With `ce_i`=0, stay in IDLE.
- ACCESS:
  - `sram_ce_n_o`=0.
  - Read: `sram_oe_n_o`=0.
  - Write: `sram_we_n_o`=0 and `sram_data_oe_o`=1.
  - Next state is WAIT if waits are enabled, else DONE.
- WAIT:
  - Strobes stay as in ACCESS. A down-counter is loaded with `WAIT_CYCLES-1` on entry.
  - Go to DONE when the counter is 0.
- DONE:
  - `sram_we_n_o` and `sram_oe_n_o` = 1.
  - `sram_ce_n_o`=0, address and write data held: gives write data hold time.
  - `rdata_valid_o`=1 for a read only.
  - Next state is IDLE.
- Read capture: `rdata_o` <= `sram_rdata_i` on the edge that leaves the last strobed state (ACCESS or WAIT).
- Writes never change `rdata_o`.
- `stall_req_o` (combinational) = (IDLE && `ce_i`) || ACCESS || WAIT. It is low in DONE, so PC advances on the edge that ends DONE.
- The latched request is used throughout. Changes on `addr_i`, `ce_i` etc. after capture are ignored. A `ce_i` drop mid-access does not abort.
- Address arithmetic: byte address bits [1:0] are ignored. Bits above `SRAM_ADDR_W+1` are ignored, so addresses wrap modulo SRAM size.

## Timing
- Reset (`rst`=1 at an edge):
  - State goes to IDLE and the wait counter to 0.
  - `rdata_o`=0 and `rdata_valid_o`=0.
  - `sram_ce_n_o`, `sram_oe_n_o`, `sram_we_n_o` = 1; `sram_be_n_o`=4'hF; `sram_data_oe_o`=0; `sram_addr_o`=0; `sram_wdata_o`=0.
  - `stall_req_o`=0 while `rst`=1 regardless of `ce_i`.
- Reset mid-access: same as above in the same edge. The write is abandoned, because `we_n` rises immediately.
- Latency with capture edge T:
  - Without waits: ACCESS T..T+1, DONE T+1..T+2. `rdata_valid_o` is high in cycle T+1→T+2. That is 3 cycles per access including the IDLE request cycle.
  - With waits: latency grows by `WAIT_CYCLES`.
- Back-to-back: DONE always returns to IDLE. The next request is captured at the earliest one cycle after DONE. There is no pipelining.
- The output strobes are registered. Only `stall_req_o` is combinational.

## Configuration
- `SRAM_WAIT_EN` defined: the WAIT state and the 3-bit counter are built. Access time is 1+`WAIT_CYCLES` strobed cycles.
- `SRAM_WAIT_EN` undefined: no WAIT state. ACCESS goes straight to DONE, and `WAIT_CYCLES` is ignored.

## Structure
- Shared package / `defines.vh` holds:
  - the state encoding: `SRAM_IDLE`, `SRAM_ACCESS`, `SRAM_WAIT`, `SRAM_DONE` (2 bits);
  - `SRAM_ADDR_W` default;
  - the existing `ROM_OP_READ`/`ROM_OP_WRITE`, `ChipEnable`, `RstEnable`.
- Optional sub-module `sram_wait_cnt`: loadable down-counter with a zero flag. It is instantiated only under `SRAM_WAIT_EN`.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles, `ce_i`=0. All strobes read 1, `stall_req_o`=0, `rdata_o`=0.
- Read, no waits: `addr_i`=0x0000_0010, SRAM model returns 0x2402_0005. `sram_addr_o`=0x4, `oe_n` low 1 cycle, `rdata_o`=0x2402_0005 with `rdata_valid_o` pulsed once. `stall_req_o` is high for exactly 2 cycles.
- Write with `SRAM_WAIT_EN`, `WAIT_CYCLES`=2: `wr_data_i`=0xDEAD_BEEF at 0x100. `we_n` low 3 cycles, `data_oe` high through DONE, and the model memory word 0x40 = 0xDEAD_BEEF. `rdata_valid_o` never rises.
- Input change mid-access: `addr_i` changes to 0x20 during ACCESS. `sram_addr_o` stays at the latched value, and the read of the original address completes.
- Reset mid-write: `rst` at the ACCESS edge. On the same edge `we_n`=1, `data_oe`=0, state IDLE, and the model memory is unchanged.
- Wrap: `addr_i`=0x0040_0004 with `SRAM_ADDR_W`=20. `sram_addr_o`=0x00001.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared encodings and constants for the base-SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    SRAM_IDLE   = 2'd0,
    SRAM_ACCESS = 2'd1,
    SRAM_WAIT   = 2'd2,
    SRAM_DONE   = 2'd3
  } sram_state_e;

  localparam int   SRAM_ADDR_W_DEF = 20;
  localparam int   WAIT_CNT_W      = 3;
  localparam logic ROM_OP_READ     = 1'b0;
  localparam logic ROM_OP_WRITE    = 1'b1;
  localparam logic ChipEnable      = 1'b1;
  localparam logic RstEnable       = 1'b1;

endpackage

// File: rtl/sram_ctrl_if.sv
// Request/response bus between the PC/fetch stage (master) and sram_ctrl (slave).
interface sram_ctrl_if;

  logic [31:0] addr_i;
  logic        ce_i;
  logic        rom_op_i;
  logic [31:0] wr_data_i;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        stall_req_o;

  modport master (
    output addr_i, ce_i, rom_op_i, wr_data_i,
    input  rdata_o, rdata_valid_o, stall_req_o
  );

  modport slave (
    input  addr_i, ce_i, rom_op_i, wr_data_i,
    output rdata_o, rdata_valid_o, stall_req_o
  );

endinterface

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter with zero flag; stretches the strobed phase of an access.
module sram_wait_cnt
  import sram_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [WAIT_CNT_W-1:0] load_val_i,
  input  logic                  dec_i,
  output logic                  zero_o
);

  logic [WAIT_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Multi-cycle base-SRAM read/write controller with stall request to CTRL.
// Optional wait states are built when SRAM_WAIT_EN is defined.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int SRAM_ADDR_W = SRAM_ADDR_W_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_ctrl_if.slave             req,
  output logic [SRAM_ADDR_W-1:0] sram_addr_o,
  output logic [31:0]            sram_wdata_o,
  input  logic [31:0]            sram_rdata_i,
  output logic                   sram_data_oe_o,
  output logic                   sram_ce_n_o,
  output logic                   sram_oe_n_o,
  output logic                   sram_we_n_o,
  output logic [3:0]             sram_be_n_o
);

  sram_state_e            state_q;
  logic                   is_write_q;
  logic [SRAM_ADDR_W-1:0] addr_q;
  logic [31:0]            wdata_q;
  logic [31:0]            rdata_q;
  logic                   rdata_valid_q;
  logic                   ce_n_q, oe_n_q, we_n_q, data_oe_q;
  logic                   op_write;
  logic                   strobe_end;
  logic                   unused_addr_bits;

  assign op_write = (req.rom_op_i == ROM_OP_WRITE);
  // Byte-offset bits and bits beyond the SRAM size are dropped: addresses wrap.
  assign unused_addr_bits = ^{req.addr_i[31:SRAM_ADDR_W+2], req.addr_i[1:0]};

`ifdef SRAM_WAIT_EN
  logic wait_zero;

  sram_wait_cnt u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == SRAM_ACCESS),
    .load_val_i (WAIT_CNT_W'(WAIT_CYCLES - 1)),
    .dec_i      (state_q == SRAM_WAIT),
    .zero_o     (wait_zero)
  );

  assign strobe_end = (state_q == SRAM_WAIT) && wait_zero;
`else
  logic [WAIT_CNT_W-1:0] unused_wait_cfg;

  assign unused_wait_cfg = WAIT_CNT_W'(WAIT_CYCLES);
  assign strobe_end      = (state_q == SRAM_ACCESS);
`endif

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q       <= SRAM_IDLE;
      is_write_q    <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      ce_n_q        <= 1'b1;
      oe_n_q        <= 1'b1;
      we_n_q        <= 1'b1;
      data_oe_q     <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      case (state_q)
        SRAM_IDLE: begin
          if (req.ce_i == ChipEnable) begin
            addr_q     <= req.addr_i[SRAM_ADDR_W+1:2];
            wdata_q    <= req.wr_data_i;
            is_write_q <= op_write;
            ce_n_q     <= 1'b0;
            oe_n_q     <= op_write;
            we_n_q     <= !op_write;
            data_oe_q  <= op_write;
            state_q    <= SRAM_ACCESS;
          end
        end
        SRAM_ACCESS, SRAM_WAIT: begin
          if (strobe_end) begin
            // Release OE/WE but keep CE, address and data for hold time.
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            state_q <= SRAM_DONE;
            if (!is_write_q) begin
              rdata_q       <= sram_rdata_i;
              rdata_valid_q <= 1'b1;
            end
          end else if (state_q == SRAM_ACCESS) begin
            state_q <= SRAM_WAIT;
          end
        end
        SRAM_DONE: begin
          ce_n_q    <= 1'b1;
          data_oe_q <= 1'b0;
          state_q   <= SRAM_IDLE;
        end
        default: state_q <= SRAM_IDLE;
      endcase
    end
  end

  assign req.stall_req_o   = (rst != RstEnable) &&
                             (((state_q == SRAM_IDLE) && (req.ce_i == ChipEnable)) ||
                              (state_q == SRAM_ACCESS) || (state_q == SRAM_WAIT));
  assign req.rdata_o       = rdata_q;
  assign req.rdata_valid_o = rdata_valid_q;
  assign sram_addr_o       = addr_q;
  assign sram_wdata_o      = wdata_q;
  assign sram_ce_n_o       = ce_n_q;
  assign sram_oe_n_o       = oe_n_q;
  assign sram_we_n_o       = we_n_q;
  assign sram_data_oe_o    = data_oe_q;
  assign sram_be_n_o       = {4{ce_n_q}};

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: read/write timing, reset, wrap, and a read scoreboard.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

`ifdef SRAM_WAIT_EN
  localparam int WAITS = 2;
`else
  localparam int WAITS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] sram_addr_o;
  logic [31:0] sram_wdata_o;
  logic [31:0] sram_rdata;
  logic        sram_data_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
  logic [3:0]  sram_be_n_o;

  int n_cmp = 0;
  int n_err = 0;
  int n_valid = 0;
  int n_reads = 0;
  logic [31:0] exp_q[$];

  logic [31:0] mem [0:255];
  logic        prev_we_n = 1'b1;

  sram_ctrl_if bus ();

  sram_ctrl #(.SRAM_ADDR_W(20), .WAIT_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (bus),
    .sram_addr_o    (sram_addr_o),
    .sram_wdata_o   (sram_wdata_o),
    .sram_rdata_i   (sram_rdata),
    .sram_data_oe_o (sram_data_oe_o),
    .sram_ce_n_o    (sram_ce_n_o),
    .sram_oe_n_o    (sram_oe_n_o),
    .sram_we_n_o    (sram_we_n_o),
    .sram_be_n_o    (sram_be_n_o)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM model: drives data while CE/OE low, commits a write when WE rises with CE still low.
  always_comb sram_rdata = (!sram_ce_n_o && !sram_oe_n_o) ? mem[sram_addr_o[7:0]] : 32'hBAD0_BAD0;

  always @(negedge clk) begin
    if (!prev_we_n && sram_we_n_o && !sram_ce_n_o) mem[sram_addr_o[7:0]] <= sram_wdata_o;
    prev_we_n <= sram_we_n_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rdata_valid pulse must match the oldest expected read.
  always @(negedge clk) begin
    if (!rst && bus.rdata_valid_o) begin
      n_valid++;
      if (exp_q.size() == 0) check("rdata_valid unexpected", {31'b0, bus.rdata_valid_o}, 32'h0);
      else check("rdata_o", bus.rdata_o, exp_q.pop_front());
    end
  end

  task automatic do_access(input string name, input logic [31:0] a, input logic op,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input logic [19:0] exp_word, input bit chg_addr, input bit rst_mid);
    int stall_c = 0;
    int we_c = 0;
    int oe_c = 0;
    bit done = 1'b0;
    bit is_wr = (op == ROM_OP_WRITE);
    if (!is_wr) begin
      exp_q.push_back(exp_rd);
      n_reads++;
    end
    @(negedge clk);
    bus.addr_i = a; bus.ce_i = 1'b1; bus.rom_op_i = op; bus.wr_data_i = wd;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.stall_req_o) stall_c++;
      if (!sram_we_n_o) we_c++;
      if (!sram_oe_n_o) oe_c++;
      if (c > 0 && !bus.stall_req_o) begin
        done = 1'b1;
        break;
      end
      if (c == 1) begin
        check({name, " addr ACCESS"}, {12'b0, sram_addr_o}, {12'b0, exp_word});
        check({name, " be_n ACCESS"}, {28'b0, sram_be_n_o}, 32'h0);
        if (rst_mid) rst = 1'b1;
        else bus.ce_i = 1'b0;
        if (chg_addr) bus.addr_i = 32'h0000_0020;
      end
      @(negedge clk);
    end
    check({name, " completes"}, {31'b0, done}, 32'd1);
    if (rst_mid) begin
      check({name, " we_n reset"}, {31'b0, sram_we_n_o}, 32'd1);
      check({name, " data_oe reset"}, {31'b0, sram_data_oe_o}, 32'd0);
      check({name, " ce_n reset"}, {31'b0, sram_ce_n_o}, 32'd1);
      check({name, " rdata reset"}, bus.rdata_o, 32'h0);
      rst = 1'b0; bus.ce_i = 1'b0;
      @(negedge clk); #1;
      check({name, " mem unchanged"}, mem[exp_word[7:0]], exp_rd);
    end else begin
      check({name, " stall cycles"}, stall_c, 2 + WAITS);
      check({name, " we_n low cycles"}, we_c, is_wr ? 1 + WAITS : 0);
      check({name, " oe_n low cycles"}, oe_c, is_wr ? 0 : 1 + WAITS);
      check({name, " addr DONE"}, {12'b0, sram_addr_o}, {12'b0, exp_word});
      check({name, " ce_n DONE"}, {31'b0, sram_ce_n_o}, 32'd0);
      check({name, " data_oe DONE"}, {31'b0, sram_data_oe_o}, {31'b0, is_wr});
      check({name, " valid DONE"}, {31'b0, bus.rdata_valid_o}, {31'b0, !is_wr});
      @(negedge clk); #1;
      check({name, " ce_n IDLE"}, {31'b0, sram_ce_n_o}, 32'd1);
      check({name, " be_n IDLE"}, {28'b0, sram_be_n_o}, 32'hF);
      check({name, " data_oe IDLE"}, {31'b0, sram_data_oe_o}, 32'd0);
      if (is_wr) check({name, " mem word"}, mem[exp_word[7:0]], wd);
    end
    $display("txn %s op=%0d addr=%h word=%h stall=%0d we=%0d oe=%0d", name, op, a, exp_word,
             stall_c, we_c, oe_c);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'h2402_0005;
    mem[2] = 32'hCAFE_0002;
    mem[8] = 32'h0BAD_0008;
    mem[1] = 32'h1111_0001;
    bus.addr_i = 32'h0; bus.ce_i = 1'b0; bus.rom_op_i = ROM_OP_READ; bus.wr_data_i = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset ce_n", {31'b0, sram_ce_n_o}, 32'd1);
    check("reset oe_n", {31'b0, sram_oe_n_o}, 32'd1);
    check("reset we_n", {31'b0, sram_we_n_o}, 32'd1);
    check("reset be_n", {28'b0, sram_be_n_o}, 32'hF);
    check("reset data_oe", {31'b0, sram_data_oe_o}, 32'd0);
    check("reset addr", {12'b0, sram_addr_o}, 32'h0);
    check("reset wdata", sram_wdata_o, 32'h0);
    check("reset stall", {31'b0, bus.stall_req_o}, 32'd0);
    check("reset rdata", bus.rdata_o, 32'h0);
    check("reset valid", {31'b0, bus.rdata_valid_o}, 32'd0);
    rst = 1'b0;
    $display("txn reset idle");

    do_access("read_0x10",  32'h0000_0010, ROM_OP_READ,  32'h0,         32'h2402_0005, 20'h00004, 1'b0, 1'b0);
    do_access("write_0x100", 32'h0000_0100, ROM_OP_WRITE, 32'hDEAD_BEEF, 32'h0,         20'h00040, 1'b0, 1'b0);
    do_access("readback",   32'h0000_0100, ROM_OP_READ,  32'h0,         32'hDEAD_BEEF, 20'h00040, 1'b0, 1'b0);
    do_access("addr_change", 32'h0000_0008, ROM_OP_READ,  32'h0,         32'hCAFE_0002, 20'h00002, 1'b1, 1'b0);
    do_access("rst_mid_wr", 32'h0000_0200, ROM_OP_WRITE, 32'h1234_5678, 32'h0,         20'h00080, 1'b0, 1'b1);
    do_access("wrap",       32'h0040_0004, ROM_OP_READ,  32'h0,         32'h1111_0001, 20'h00001, 1'b0, 1'b0);
    do_access("unaligned",  32'h0000_0013, ROM_OP_READ,  32'h0,         32'h2402_0005, 20'h00004, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("valid pulses", n_valid, n_reads);
    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
